// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues icache requests, applies
// redirects/stalls/halt and produces the IF/ID payload and controls.
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter int unsigned PC_INC  = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        stall,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_npc,
    output logic        if_valid,
    output logic        if_id_en,
    output logic        if_id_flush,
    output logic [31:0] fetch_cnt
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t            state_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   pend_pc_q;
    logic [XLEN-1:0]   fetch_cnt_q;

    logic [XLEN-1:0]   pc_inc_c;
    logic [XLEN-1:0]   redir_pc_c;
    logic              issue_c;

    // Sequential PC, word-aligned redirect target, and "real instruction issued" qualifier
    always_comb begin
        pc_inc_c   = pc_q + XLEN'(PC_INC);
        redir_pc_c = redirect_pc & ~XLEN'(3);
        issue_c    = (state_q == RUN) & ~halt & ~redirect_en & ~stall & ihit;
    end

    // Fetch control FSM: PC, pending redirect target and issue counter
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= RUN;
            pc_q        <= PC_INIT;
            pend_pc_q   <= '0;
            fetch_cnt_q <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (halt) begin
                        state_q <= HALTED;
                    end else if (redirect_en) begin
                        if (ihit) begin
                            pc_q <= redir_pc_c;
                        end else begin
                            // Outstanding miss cannot be aborted; remember the target
                            pend_pc_q <= redir_pc_c;
                            state_q   <= DRAIN;
                        end
                    end else if (issue_c) begin
                        pc_q        <= pc_inc_c;
                        fetch_cnt_q <= fetch_cnt_q + XLEN'(1);
                    end
                end
                DRAIN: begin
                    if (halt) begin
                        state_q <= HALTED;
                    end else begin
                        if (redirect_en) begin
                            pend_pc_q <= redir_pc_c;
                        end
                        if (ihit) begin
                            pc_q    <= redirect_en ? redir_pc_c : pend_pc_q;
                            state_q <= RUN;
                        end
                    end
                end
                HALTED: begin
                    state_q <= HALTED;
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    // Icache request, IF/ID payload and IF/ID controls
    always_comb begin
        imemREN     = (state_q != HALTED);
        imemaddr    = pc_q;
        if_valid    = issue_c;
        if_instr    = issue_c ? imemload : '0;
        if_pc       = pc_q;
        if_npc      = pc_inc_c;
        if_id_en    = ~stall | redirect_en;
        if_id_flush = redirect_en & (state_q != HALTED);
        fetch_cnt   = fetch_cnt_q;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// traffic against a behavioural reference model.
module tb_fetch_stage;

    logic        CLK;
    logic        nRST;
    logic        ihit;
    logic [31:0] imemload;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        stall;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        halt;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_npc;
    logic        if_valid;
    logic        if_id_en;
    logic        if_id_flush;
    logic [31:0] fetch_cnt;

    int n_vec;
    int n_err;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_pend;
    logic [31:0] m_cnt;
    bit          m_drain;
    bit          m_halted;

    fetch_stage dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .ihit        (ihit),
        .imemload    (imemload),
        .imemREN     (imemREN),
        .imemaddr    (imemaddr),
        .stall       (stall),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_npc      (if_npc),
        .if_valid    (if_valid),
        .if_id_en    (if_id_en),
        .if_id_flush (if_id_flush),
        .fetch_cnt   (fetch_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic model_reset();
        m_pc     = 32'h0;
        m_pend   = 32'h0;
        m_cnt    = 32'h0;
        m_drain  = 1'b0;
        m_halted = 1'b0;
    endtask

    // Advance the model one clock using the inputs currently driven
    task automatic model_step();
        logic [31:0] tgt;
        tgt = {redirect_pc[31:2], 2'b00};
        if (m_halted) return;
        if (halt) begin
            m_halted = 1'b1;
        end else if (m_drain) begin
            if (redirect_en) m_pend = tgt;
            if (ihit) begin
                m_pc    = m_pend;
                m_drain = 1'b0;
            end
        end else if (redirect_en) begin
            if (ihit) m_pc = tgt;
            else begin
                m_pend  = tgt;
                m_drain = 1'b1;
            end
        end else if (!stall && ihit) begin
            m_pc  = m_pc + 32'd4;
            m_cnt = m_cnt + 32'd1;
        end
    endtask

    task automatic drive(input bit h, input logic [31:0] ld, input bit st,
                         input bit re, input logic [31:0] rpc, input bit hl);
        ihit        = h;
        imemload    = ld;
        stall       = st;
        redirect_en = re;
        redirect_pc = rpc;
        halt        = hl;
    endtask

    // One clock edge; returns at the following falling edge
    task automatic tick();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        nRST = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        model_reset();
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    // Sequential hits until the model PC reaches target
    task automatic advance_to(input logic [31:0] target);
        int guard;
        guard = 0;
        while (m_pc != target && guard < 256) begin
            drive(1'b1, $urandom, 1'b0, 1'b0, 32'h0, 1'b0);
            tick();
            guard++;
        end
        if (m_pc != target) begin
            n_vec++; n_err++;
            $display("FAIL advance_to: model pc %h never reached %h", m_pc, target);
        end
    endtask

    task automatic test_reset();
        @(negedge CLK);
        nRST = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        model_reset();
        #1;
        n_vec++;
        if ({imemREN, imemaddr, if_valid, fetch_cnt} !== {1'b1, 32'h0, 1'b0, 32'h0}) begin
            n_err++;
            $display("FAIL reset: ren=%b addr=%h valid=%b cnt=%0d, expected 1/0/0/0",
                     imemREN, imemaddr, if_valid, fetch_cnt);
        end
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_sequential();
        logic [31:0] ld;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            ld = $urandom;
            drive(1'b1, ld, 1'b0, 1'b0, 32'h0, 1'b0);
            #1;
            n_vec++;
            if ({imemaddr, if_valid, if_instr, if_pc, if_npc} !==
                {32'(i * 4), 1'b1, ld, 32'(i * 4), 32'(i * 4 + 4)}) begin
                n_err++;
                $display("FAIL seq[%0d]: addr=%h valid=%b instr=%h pc=%h npc=%h, expected addr=%h valid=1 instr=%h",
                         i, imemaddr, if_valid, if_instr, if_pc, if_npc, 32'(i * 4), ld);
            end
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        n_vec++;
        if (fetch_cnt !== 32'd4) begin
            n_err++;
            $display("FAIL seq_cnt: fetch_cnt=%0d expected 4", fetch_cnt);
        end
    endtask

    task automatic test_miss();
        do_reset();
        advance_to(32'h10);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, $urandom, 1'b0, 1'b0, 32'h0, 1'b0);
            #1;
            n_vec++;
            if ({if_valid, if_instr, if_pc, imemaddr} !== {1'b0, 32'h0, 32'h10, 32'h10}) begin
                n_err++;
                $display("FAIL miss_bubble[%0d]: valid=%b instr=%h pc=%h addr=%h, expected 0/0/10/10",
                         i, if_valid, if_instr, if_pc, imemaddr);
            end
            tick();
        end
        drive(1'b1, 32'h2402_0005, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        n_vec++;
        if ({if_valid, if_instr, if_pc} !== {1'b1, 32'h2402_0005, 32'h10}) begin
            n_err++;
            $display("FAIL miss_hit: valid=%b instr=%h pc=%h, expected 1/24020005/10",
                     if_valid, if_instr, if_pc);
        end
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        n_vec++;
        if (imemaddr !== 32'h14) begin
            n_err++;
            $display("FAIL miss_next: addr=%h expected 14", imemaddr);
        end
    endtask

    task automatic test_redirect_hit();
        do_reset();
        advance_to(32'h20);
        drive(1'b1, $urandom, 1'b0, 1'b1, 32'h100, 1'b0);
        #1;
        n_vec++;
        if ({if_id_flush, if_valid, if_id_en} !== 3'b101) begin
            n_err++;
            $display("FAIL redir_hit: flush=%b valid=%b en=%b, expected 1/0/1",
                     if_id_flush, if_valid, if_id_en);
        end
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        n_vec++;
        if ({imemaddr, fetch_cnt} !== {32'h100, 32'd8}) begin
            n_err++;
            $display("FAIL redir_hit_next: addr=%h cnt=%0d, expected 100/8", imemaddr, fetch_cnt);
        end
    endtask

    task automatic test_redirect_miss();
        do_reset();
        advance_to(32'h20);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h200, 1'b0);
        #1;
        n_vec++;
        if ({imemaddr, if_valid, if_id_flush} !== {32'h20, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL drain_redir: addr=%h valid=%b flush=%b, expected 20/0/1",
                     imemaddr, if_valid, if_id_flush);
        end
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        n_vec++;
        if ({imemaddr, if_valid, if_instr} !== {32'h20, 1'b0, 32'h0}) begin
            n_err++;
            $display("FAIL drain_hit: addr=%h valid=%b instr=%h, expected 20/0/0",
                     imemaddr, if_valid, if_instr);
        end
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        n_vec++;
        if ({imemaddr, imemREN, fetch_cnt} !== {32'h200, 1'b1, 32'd8}) begin
            n_err++;
            $display("FAIL drain_next: addr=%h ren=%b cnt=%0d, expected 200/1/8",
                     imemaddr, imemREN, fetch_cnt);
        end
    endtask

    task automatic test_stall();
        do_reset();
        advance_to(32'h40);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, $urandom, 1'b1, 1'b0, 32'h0, 1'b0);
            #1;
            n_vec++;
            if ({if_id_en, imemaddr} !== {1'b0, 32'h40}) begin
                n_err++;
                $display("FAIL stall[%0d]: en=%b addr=%h, expected 0/40", i, if_id_en, imemaddr);
            end
            tick();
        end
        // Misaligned target: low bits must be dropped
        drive(1'b1, $urandom, 1'b1, 1'b1, 32'h83, 1'b0);
        #1;
        n_vec++;
        if ({if_id_en, if_id_flush, fetch_cnt} !== {1'b1, 1'b1, 32'd16}) begin
            n_err++;
            $display("FAIL stall_redir: en=%b flush=%b cnt=%0d, expected 1/1/16",
                     if_id_en, if_id_flush, fetch_cnt);
        end
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        n_vec++;
        if (imemaddr !== 32'h80) begin
            n_err++;
            $display("FAIL stall_redir_next: addr=%h expected 80", imemaddr);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        drive(1'b1, $urandom, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
        tick();
        drive(1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        n_vec++;
        if ({imemaddr, if_npc, if_valid} !== {32'hFFFF_FFFC, 32'h0, 1'b1}) begin
            n_err++;
            $display("FAIL wrap: addr=%h npc=%h valid=%b, expected fffffffc/0/1",
                     imemaddr, if_npc, if_valid);
        end
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        n_vec++;
        if (imemaddr !== 32'h0) begin
            n_err++;
            $display("FAIL wrap_next: addr=%h expected 0", imemaddr);
        end
    endtask

    task automatic test_halt();
        do_reset();
        advance_to(32'h60);
        drive(1'b1, $urandom, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'($urandom), $urandom, 1'($urandom), 1'($urandom), $urandom, 1'($urandom));
            #1;
            n_vec++;
            if ({imemREN, if_valid, imemaddr, fetch_cnt} !== {1'b0, 1'b0, 32'h60, 32'd24}) begin
                n_err++;
                $display("FAIL halted[%0d]: ren=%b valid=%b addr=%h cnt=%0d, expected 0/0/60/24",
                         i, imemREN, if_valid, imemaddr, fetch_cnt);
            end
            tick();
        end
        nRST = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        model_reset();
        #1;
        n_vec++;
        if ({imemREN, imemaddr, fetch_cnt} !== {1'b1, 32'h0, 32'h0}) begin
            n_err++;
            $display("FAIL halt_reset: ren=%b addr=%h cnt=%0d, expected 1/0/0",
                     imemREN, imemaddr, fetch_cnt);
        end
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_reset_in_drain();
        do_reset();
        advance_to(32'h8);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h300, 1'b0);
        tick();
        do_reset();
        drive(1'b1, 32'h0BAD_0001, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        n_vec++;
        if ({imemaddr, if_valid, if_instr} !== {32'h0, 1'b1, 32'h0BAD_0001}) begin
            n_err++;
            $display("FAIL drain_reset: addr=%h valid=%b instr=%h, expected 0/1/0bad0001",
                     imemaddr, if_valid, if_instr);
        end
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        n_vec++;
        if (imemaddr !== 32'h4) begin
            n_err++;
            $display("FAIL drain_reset_next: addr=%h expected 4", imemaddr);
        end
    endtask

    task automatic test_random();
        logic [162:0] got;
        logic [162:0] exp;
        bit           e_valid;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if (m_halted && $urandom_range(0, 7) == 0) do_reset();
            else if ($urandom_range(0, 299) == 0) do_reset();
            drive($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 5) == 0, $urandom, $urandom_range(0, 199) == 0);
            #1;
            e_valid = !m_halted && !m_drain && !halt && !redirect_en && !stall && ihit;
            exp = {!m_halted, m_pc, e_valid, (e_valid ? imemload : 32'h0), m_pc,
                   m_pc + 32'd4, (!stall || redirect_en), (redirect_en && !m_halted), m_cnt};
            got = {imemREN, imemaddr, if_valid, if_instr, if_pc, if_npc, if_id_en, if_id_flush, fetch_cnt};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL random[%0d]: got %h expected %h", i, got, exp);
            end
            tick();
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        nRST  = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        model_reset();
        test_reset();
        test_sequential();
        test_miss();
        test_redirect_hit();
        test_redirect_miss();
        test_stall();
        test_wrap();
        test_halt();
        test_reset_in_drain();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
